// File: rtl/rv_writeback_mo.sv
// ---------------------------------------------------------------------------
// rv_writeback_mo -- memory-ordered writeback stage
//
// Tracks outstanding loads in an in-order tag FIFO and outstanding stores in
// a counter, retires load data to the register file as completions arrive,
// and merges ALU results into the single register-file write port.
//
// Parameters:
//   LOAD_DEPTH  (1..4) maximum outstanding loads
//   STORE_DEPTH (1..7) maximum outstanding stores
//
// Optional feature macro: URV_WB_MISALIGN_EN
//   defined   : misaligned H/HU/L loads raise x_misaligned_o and are dropped
//   undefined : x_misaligned_o is 0, low address bits only select the lane
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   w_stall_i              pipeline stall, x-side inputs ignored while high
//   w_stall_req_o          ask upstream to hold the x-side inputs
//   x_valid_i .. x_rs2_i   instruction presented by the execute stage
//   dm_data_l_i            load data, valid with dm_load_done_i
//   dm_load_done_i         in-order load completion pulse
//   dm_store_done_i        in-order store completion pulse
//   rf_rd_value_o/rd_o/rd_write_o   register-file write port
//   x_misaligned_o         misaligned-load exception
//   wb_idle_o              no loads or stores outstanding
// ---------------------------------------------------------------------------
module rv_writeback_mo #(
   parameter int LOAD_DEPTH  = 2,
   parameter int STORE_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        w_stall_i,
   output logic        w_stall_req_o,
   input  logic        x_valid_i,
   input  logic [2:0]  x_fun_i,
   input  logic        x_load_i,
   input  logic        x_store_i,
   input  logic [31:0] x_dm_addr_i,
   input  logic [4:0]  x_rd_i,
   input  logic [31:0] x_rd_value_i,
   input  logic        x_rd_write_i,
   input  logic [4:0]  x_rs1_i,
   input  logic [4:0]  x_rs2_i,
   input  logic [31:0] dm_data_l_i,
   input  logic        dm_load_done_i,
   input  logic        dm_store_done_i,
   output logic [31:0] rf_rd_value_o,
   output logic [4:0]  rf_rd_o,
   output logic        rf_rd_write_o,
   output logic        x_misaligned_o,
   output logic        wb_idle_o
);

   localparam logic [2:0] LDST_B  = 3'b000;
   localparam logic [2:0] LDST_H  = 3'b001;
   localparam logic [2:0] LDST_L  = 3'b010;
   localparam logic [2:0] LDST_BU = 3'b100;
   localparam logic [2:0] LDST_HU = 3'b101;

   // Storage is sized for the largest legal depth; only LOAD_DEPTH slots are used.
   localparam logic [3:0] LMASK = 4'((1 << LOAD_DEPTH) - 1);
   localparam logic [1:0] LAST  = 2'(LOAD_DEPTH - 1);
   localparam logic [2:0] SMAX  = 3'(STORE_DEPTH);

   // Select the addressed lane of the load word and sign/zero extend it.
   function automatic logic [31:0] load_align(input logic [2:0]  fun,
                                              input logic [1:0]  off,
                                              input logic [31:0] data);
      logic [7:0]  byte_v;
      logic [15:0] half_v;
      logic [31:0] res_v;
      byte_v = 8'(data >> {off, 3'b000});
      half_v = off[1] ? data[31:16] : data[15:0];
      case (fun)
         LDST_B:  res_v = {{24{byte_v[7]}}, byte_v};
         LDST_BU: res_v = {24'h00_0000, byte_v};
         LDST_H:  res_v = {{16{half_v[15]}}, half_v};
         LDST_HU: res_v = {16'h0000, half_v};
         LDST_L:  res_v = data;
         default: res_v = data;
      endcase
      return res_v;
   endfunction

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == LAST) ? 2'b00 : p + 2'b01;
   endfunction

   logic [4:0] tag_rd_r  [0:3];
   logic [2:0] tag_fun_r [0:3];
   logic [1:0] tag_off_r [0:3];
   logic [3:0] tag_vld_r;
   logic [1:0] wr_ptr_r;
   logic [1:0] rd_ptr_r;
   logic [2:0] st_cnt_r;

   logic        fifo_empty_s;
   logic        fifo_full_s;
   logic        hazard_s;
   logic        pop_s;
   logic        alu_conflict_s;
   logic        stall_req_s;
   logic        go_s;
   logic        addr_mis_s;
   logic        mis_s;
   logic        push_s;
   logic        alu_wr_s;
   logic        st_inc_s;
   logic        st_dec_s;
   logic [3:0]  set_mask_s;
   logic [3:0]  clr_mask_s;
   logic [31:0] load_val_s;
   logic        addr_hi_unused_s;

   assign addr_hi_unused_s = ^x_dm_addr_i[31:2];

   assign fifo_empty_s = (tag_vld_r == 4'b0000);
   assign fifo_full_s  = ((tag_vld_r & LMASK) == LMASK);

   // Source or destination of the incoming instruction matches a pending load rd.
   always_comb begin
      hazard_s = 1'b0;
      for (int i = 0; i < 4; i++) begin
         hazard_s = hazard_s | (tag_vld_r[i] &
                    (((x_rs1_i != 5'd0) && (x_rs1_i == tag_rd_r[i])) ||
                     ((x_rs2_i != 5'd0) && (x_rs2_i == tag_rd_r[i])) ||
                     ((x_rd_i  != 5'd0) && (x_rd_i  == tag_rd_r[i]))));
      end
   end

`ifdef URV_WB_MISALIGN_EN
   assign addr_mis_s = (((x_fun_i == LDST_H) || (x_fun_i == LDST_HU)) && x_dm_addr_i[0]) ||
                       ((x_fun_i == LDST_L) && (x_dm_addr_i[1:0] != 2'b00));
`else
   assign addr_mis_s = 1'b0;
`endif

   // Load retirement ignores w_stall_i; an empty FIFO swallows the pulse.
   assign pop_s = !rst_i && dm_load_done_i && !fifo_empty_s;

   // An ALU write colliding with a retiring load is held back one cycle.
   assign alu_conflict_s = !x_load_i && x_rd_write_i && (x_rd_i != 5'd0) && pop_s;

   assign stall_req_s = !rst_i && x_valid_i &&
                        ((x_load_i && fifo_full_s) ||
                         (x_store_i && (st_cnt_r == SMAX)) ||
                         hazard_s || alu_conflict_s);

   assign go_s     = !rst_i && x_valid_i && !w_stall_i && !stall_req_s;
   assign mis_s    = go_s && x_load_i && addr_mis_s;
   assign push_s   = go_s && x_load_i && !addr_mis_s;
   assign alu_wr_s = go_s && !x_load_i && x_rd_write_i;
   assign st_inc_s = go_s && x_store_i;
   assign st_dec_s = !rst_i && dm_store_done_i && (st_cnt_r != 3'd0);

   // One-hot set/clear masks for the FIFO slot valid bits.
   always_comb begin
      set_mask_s = 4'b0000;
      clr_mask_s = 4'b0000;
      if (push_s) begin
         set_mask_s = 4'b0001 << wr_ptr_r;
      end else begin
         set_mask_s = 4'b0000;
      end
      if (pop_s) begin
         clr_mask_s = 4'b0001 << rd_ptr_r;
      end else begin
         clr_mask_s = 4'b0000;
      end
   end

   assign load_val_s = load_align(tag_fun_r[rd_ptr_r], tag_off_r[rd_ptr_r], dm_data_l_i);

   // Register-file write port: a retiring load has priority over the ALU result.
   always_comb begin
      rf_rd_write_o = 1'b0;
      rf_rd_o       = 5'd0;
      rf_rd_value_o = 32'h0000_0000;
      if (pop_s) begin
         rf_rd_write_o = (tag_rd_r[rd_ptr_r] != 5'd0);
         rf_rd_o       = tag_rd_r[rd_ptr_r];
         rf_rd_value_o = load_val_s;
      end else if (alu_wr_s) begin
         rf_rd_write_o = (x_rd_i != 5'd0);
         rf_rd_o       = x_rd_i;
         rf_rd_value_o = x_rd_value_i;
      end else begin
         rf_rd_write_o = 1'b0;
      end
   end

   assign w_stall_req_o  = stall_req_s;
   assign x_misaligned_o = mis_s;
   assign wb_idle_o      = fifo_empty_s && (st_cnt_r == 3'd0);

   // Load-tag FIFO: slot payload, valid bits and wrapping pointers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < 4; i++) begin
            tag_rd_r[i]  <= 5'd0;
            tag_fun_r[i] <= 3'd0;
            tag_off_r[i] <= 2'd0;
         end
         tag_vld_r <= 4'b0000;
         wr_ptr_r  <= 2'b00;
         rd_ptr_r  <= 2'b00;
      end else begin
         if (push_s) begin
            tag_rd_r[wr_ptr_r]  <= x_rd_i;
            tag_fun_r[wr_ptr_r] <= x_fun_i;
            tag_off_r[wr_ptr_r] <= x_dm_addr_i[1:0];
            wr_ptr_r            <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         tag_vld_r <= (tag_vld_r | set_mask_s) & ~clr_mask_s;
      end
   end

   // Outstanding-store counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         st_cnt_r <= 3'd0;
      end else begin
         case ({st_inc_s, st_dec_s})
            2'b10:   st_cnt_r <= st_cnt_r + 3'd1;
            2'b01:   st_cnt_r <= st_cnt_r - 3'd1;
            default: st_cnt_r <= st_cnt_r;
         endcase
      end
   end

endmodule
